// File: rtl/ysyx_23060203_pkg.sv
// Shared constants and types for the GPR scoreboard.
package ysyx_23060203_pkg;

  localparam int unsigned NR_GPR    = 32;
  localparam int unsigned GPR_IDX_W = 5;
  localparam int unsigned SB_CNT_W  = 2;

  typedef logic [GPR_IDX_W-1:0] gpr_idx_t;

endpackage

// File: rtl/ysyx_23060203_sb_cnt.sv
// Saturating up/down counter for one register's in-flight writes.
// inc adds one and dec removes 0..2. Leaving the range clamps the count and
// raises ovf or unf for that cycle only.
module ysyx_23060203_sb_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nz,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  // Two guard bits cover the +1 overshoot and the -2 borrow.
  localparam int unsigned SumW = CNT_W + 2;
  localparam logic [SumW-1:0] CntMax = SumW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SumW-1:0]  up, down, res;

  // Net update with clamping at both ends.
  always_comb begin
    up    = SumW'(cnt_q) + SumW'(inc);
    down  = SumW'(dec);
    res   = up - down;
    cnt_d = cnt_q;
    ovf   = 1'b0;
    unf   = 1'b0;
    if (up < down) begin
      unf   = 1'b1;
      cnt_d = '0;
    end else if (res > CntMax) begin
      ovf   = 1'b1;
      cnt_d = cnt_q;
    end else begin
      cnt_d = res[CNT_W-1:0];
    end
  end

  // Counter state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign nz   = |cnt_q;
  assign full = &cnt_q;

endmodule

// File: rtl/ysyx_23060203_scoreboard.sv
// GPR scoreboard. Each register counts its issued destinations that have not
// yet been written back. The IDU stalls on a pending source operand, or on a
// destination whose counter is saturated. x0 is never tracked.
module ysyx_23060203_scoreboard
  import ysyx_23060203_pkg::*;
#(
  parameter int unsigned NR_REG = NR_GPR,
  parameter int unsigned CNT_W  = SB_CNT_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [$clog2(NR_REG)-1:0] q_rs1,
  input  logic                      q_rs1_use,
  input  logic [$clog2(NR_REG)-1:0] q_rs2,
  input  logic                      q_rs2_use,
  input  logic [$clog2(NR_REG)-1:0] q_rd,
  output logic                      stall,
  input  logic                      iss_fire,
  input  logic [$clog2(NR_REG)-1:0] iss_rd,
  input  logic                      wb_en,
  input  logic [$clog2(NR_REG)-1:0] wb_rd,
  input  logic                      kill_en,
  input  logic [$clog2(NR_REG)-1:0] kill_rd,
  output logic [NR_REG-1:0]         pending,
  output logic                      busy,
  output logic                      err
);

  localparam int unsigned IdxW = $clog2(NR_REG);

  logic [NR_REG-1:0] nz_vec, full_vec, ovf_vec, unf_vec;
  logic              err_q;

  for (genvar i = 0; i < NR_REG; i++) begin : g_reg
    if (i == 0) begin : g_x0
      assign nz_vec[i]   = 1'b0;
      assign full_vec[i] = 1'b0;
      assign ovf_vec[i]  = 1'b0;
      assign unf_vec[i]  = 1'b0;
    end else begin : g_cnt
      logic             inc;
      logic [1:0]       dec;
      logic [CNT_W-1:0] cnt;

      assign inc = iss_fire & (iss_rd == IdxW'(i));
      assign dec = {1'b0, wb_en & (wb_rd == IdxW'(i))}
                 + {1'b0, kill_en & (kill_rd == IdxW'(i))};

      ysyx_23060203_sb_cnt #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (inc),
        .dec   (dec),
        .cnt   (cnt),
        .nz    (nz_vec[i]),
        .full  (full_vec[i]),
        .ovf   (ovf_vec[i]),
        .unf   (unf_vec[i])
      );

      // The pending flag must always agree with the raw count.
      always_comb begin
        assert (nz_vec[i] == (cnt != '0));
      end
    end
  end

  // Sticky error, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (|ovf_vec || |unf_vec) begin
      err_q <= 1'b1;
    end
  end

  // No writeback bypass: the stall is released only by the registered counts.
  assign stall = (q_rs1_use & nz_vec[q_rs1])
               | (q_rs2_use & nz_vec[q_rs2])
               | ((q_rd != '0) & full_vec[q_rd]);

  assign pending = nz_vec;
  assign busy    = |nz_vec;
  assign err     = err_q;

endmodule
